// File: rtl/mips_byte_mem_responder.sv
// Byte-wide memory target for the multicycle MIPS core: valid/ready request,
// WAIT wait states, then a one-cycle response carrying read data or write completion.
module mips_byte_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_M1 = 4'((WAIT > 0) ? (WAIT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    RESP    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q;
  logic [IDX_W-1:0]   addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               valid_q;
  logic               ready_q;
  logic               busy_q;
  logic               accept_s;
  logic               rsp_wr_s;
  logic [IDX_W-1:0]   rsp_idx_s;
  logic [IDX_W-1:0]   req_idx_s;
  logic               unused_addr_s;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign req_idx_s     = req_addr_i[IDX_W-1:0];
  assign unused_addr_s = ^req_addr_i;

  // With WAIT=0 the response is entered straight from IDLE, before the
  // request fields land in their capture registers, so read them live.
  assign rsp_wr_s  = (state_q == IDLE) ? req_write_i : wr_q;
  assign rsp_idx_s = (state_q == IDLE) ? req_idx_s   : addr_q;

  // Next-state logic for the request/wait/response sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept_s = 1'b1;
          if (WAIT > 0) begin
            state_d = WAITING;
            cnt_d   = WAIT_M1;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAITING: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        wr_q    <= req_write_i;
        addr_q  <= req_idx_s;
        wdata_q <= req_wdata_i;
      end
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == RESP);
      if ((state_d == RESP) && !rsp_wr_s) begin
        rdata_q <= mem[rsp_idx_s];
      end
    end
  end

  // Storage is never cleared; a write commits at the end of its response cycle.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == RESP) && wr_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_rdata_o = rdata_q;
  // A reset landing in the response cycle aborts the response as well.
  assign rsp_valid_o = valid_q & ~reset;

endmodule

// File: tb/tb_mips_byte_mem_responder.sv
// Bench for mips_byte_mem_responder: three instances (WAIT/DEPTH = 2/64, 0/256, 3/256)
// checked every cycle against a cycle-numbered transaction model, plus literal checks.
module tb_mips_byte_mem_responder;

  logic       clk;
  logic       rst       [3];
  logic       req_valid [3];
  logic       req_write [3];
  logic [7:0] req_addr  [3];
  logic [7:0] req_wdata [3];
  logic       req_ready [3];
  logic       rsp_valid [3];
  logic [7:0] rsp_rdata [3];
  logic       busy      [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  mips_byte_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT(2)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid_i(req_valid[0]), .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_ready_o(req_ready[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .busy_o(busy[0]));
  mips_byte_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT(0)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid_i(req_valid[1]), .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_ready_o(req_ready[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .busy_o(busy[1]));
  mips_byte_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT(3)) u2 (
    .clk(clk), .reset(rst[2]), .req_valid_i(req_valid[2]), .req_write_i(req_write[2]),
    .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]), .req_ready_o(req_ready[2]),
    .rsp_valid_o(rsp_valid[2]), .rsp_rdata_o(rsp_rdata[2]), .busy_o(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waits(int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic int depths(int k);
    return (k == 0) ? 64 : 256;
  endfunction

  // Model: one in-flight transaction per instance, response due at absolute cycle accept+WAIT+1.
  int         cyc = 0;
  bit         infl    [3];
  int         rsp_c   [3];
  bit         p_wr    [3];
  int         p_idx   [3];
  logic [7:0] p_dat   [3];
  logic [7:0] mmem    [3][256];
  bit         m_ready [3];
  bit         m_busy  [3];
  bit         m_valid [3];
  logic [7:0] m_rdata [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      infl[k] = 0; m_ready[k] = 1; m_busy[k] = 0; m_valid[k] = 0; m_rdata[k] = 8'h00;
      rsp_c[k] = -1; p_wr[k] = 0; p_idx[k] = 0; p_dat[k] = 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        infl[k]    = 0;
        m_rdata[k] = 8'h00;
      end else if (infl[k] && cyc == rsp_c[k]) begin
        if (p_wr[k]) mmem[k][p_idx[k]] = p_dat[k];
        infl[k] = 0;
      end else if (!infl[k] && req_valid[k]) begin
        infl[k]  = 1;
        p_wr[k]  = req_write[k];
        p_idx[k] = int'(req_addr[k]) % depths(k);
        p_dat[k] = req_wdata[k];
        rsp_c[k] = cyc + waits(k) + 1;
      end
    end
    cyc++;
    for (int k = 0; k < 3; k++) begin
      m_ready[k] = !infl[k];
      m_busy[k]  = infl[k];
      m_valid[k] = infl[k] && (cyc == rsp_c[k]);
      if (m_valid[k] && !p_wr[k]) m_rdata[k] = mmem[k][p_idx[k]];
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %02h, expected %02h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.req_ready", k), {7'd0, req_ready[k]}, {7'd0, m_ready[k]});
        chk($sformatf("u%0d.busy", k), {7'd0, busy[k]}, {7'd0, m_busy[k]});
        chk($sformatf("u%0d.rsp_valid", k), {7'd0, rsp_valid[k]}, {7'd0, m_valid[k] && !rst[k]});
        chk($sformatf("u%0d.rsp_rdata", k), rsp_rdata[k], m_rdata[k]);
      end
    end
  end

  // Present a request at a negedge and hold it until the model says it was accepted;
  // returns 1 time unit after the accepting edge (i.e. early in cycle 1).
  task automatic issue(int k, bit wr, logic [7:0] a, logic [7:0] d, bit keep);
    bit acc;
    int n = 0;
    @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = d;
    acc = m_ready[k];
    while (!acc && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      acc = m_ready[k];
      n++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL u%0d.accept_timeout: got no acceptance, expected one within 50 cycles", k);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid[k] = 1'b0;
  endtask

  // From inside cycle 1 after acceptance, move to the negedge of cycle WAIT+1.
  task automatic wait_rsp(int k);
    repeat (waits(k)) @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] fetch_b [4];

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = 8'h00; req_wdata[k] = 8'h00;
    end
    fetch_b[0] = 8'h8C; fetch_b[1] = 8'h01; fetch_b[2] = 8'h00; fetch_b[3] = 8'h20;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    chk_en = 1;

    @(negedge clk);
    chk("reset.req_ready", {7'd0, req_ready[0]}, 8'h01);
    chk("reset.busy", {7'd0, busy[0]}, 8'h00);
    chk("reset.rsp_valid", {7'd0, rsp_valid[0]}, 8'h00);
    chk("reset.rsp_rdata", rsp_rdata[0], 8'h00);

    // Write then read with WAIT=2; the address change during WAITING must not matter.
    issue(0, 1'b1, 8'h10, 8'hA5, 1'b0);
    wait_rsp(0);
    chk("wr10.rsp_valid", {7'd0, rsp_valid[0]}, 8'h01);
    chk("wr10.busy", {7'd0, busy[0]}, 8'h01);
    chk("wr10.rsp_rdata", rsp_rdata[0], 8'h00);
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0);
    req_addr[0] = 8'h11;
    wait_rsp(0);
    chk("rd10.rsp_valid", {7'd0, rsp_valid[0]}, 8'h01);
    chk("rd10.rsp_rdata", rsp_rdata[0], 8'hA5);
    @(negedge clk);
    chk("rd10.hold_rdata", rsp_rdata[0], 8'hA5);
    chk("rd10.pulse_end", {7'd0, rsp_valid[0]}, 8'h00);

    // DEPTH=64 wraps 0x41 onto 0x01.
    issue(0, 1'b1, 8'h41, 8'h77, 1'b0);
    wait_rsp(0);
    issue(0, 1'b0, 8'h01, 8'h00, 1'b0);
    wait_rsp(0);
    chk("wrap.rsp_rdata", rsp_rdata[0], 8'h77);

    // Instruction fetch sequence.
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 8'(i), fetch_b[i], 1'b0);
      wait_rsp(0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 8'(i), 8'h00, 1'b0);
      wait_rsp(0);
      chk($sformatf("fetch%0d.rsp_valid", i + 1), {7'd0, rsp_valid[0]}, 8'h01);
      chk($sformatf("fetch%0d.rsp_rdata", i + 1), rsp_rdata[0], fetch_b[i]);
    end

    // WAIT=0 with req_valid held high: accepts at cycles 0 and 2.
    issue(1, 1'b1, 8'h03, 8'h3C, 1'b1);
    @(negedge clk);
    chk("b2b.ready_in_resp", {7'd0, req_ready[1]}, 8'h00);
    chk("b2b.wr_rsp_valid", {7'd0, rsp_valid[1]}, 8'h01);
    issue(1, 1'b0, 8'h03, 8'h00, 1'b0);
    wait_rsp(1);
    chk("b2b.rd_rsp_valid", {7'd0, rsp_valid[1]}, 8'h01);
    chk("b2b.rd_rsp_rdata", rsp_rdata[1], 8'h3C);

    // WAIT=3: reset in the RESP cycle suppresses both the write and the response.
    issue(2, 1'b1, 8'h20, 8'h11, 1'b0);
    wait_rsp(2);
    issue(2, 1'b1, 8'h20, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk("abort.rsp_valid", {7'd0, rsp_valid[2]}, 8'h00);
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(negedge clk);
    chk("abort.req_ready", {7'd0, req_ready[2]}, 8'h01);
    chk("abort.busy", {7'd0, busy[2]}, 8'h00);
    issue(2, 1'b0, 8'h20, 8'h00, 1'b0);
    wait_rsp(2);
    chk("abort.rd_rsp_valid", {7'd0, rsp_valid[2]}, 8'h01);
    chk("abort.rd_rsp_rdata", rsp_rdata[2], 8'h11);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
